sram_mem_ctrl: RTL and testbench

Data-memory responder for the ARM pipeline's MEM stage. It accepts a single 32-bit load or store request and completes it as two 16-bit accesses to an external asynchronous SRAM. It returns the load word that the MEM/WB pipeline register captures as its memory read value. While busy it deasserts `ready`, which the hazard/freeze logic uses to stall every pipeline register.

---
 rtl/sram_mem_ctrl.sv | 131 +++++++++++++
 tb/tb_sram_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: 32-bit MEM-stage load/store done as two 16-bit async SRAM accesses.
// Optional `SRAM_CTRL_ADDR_CHECK_EN: out-of-range/misaligned requests skip to DONE and set err.
`timescale 1ns/1ps
module sram_mem_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state;
  state_t             state_nx;
  logic [2:0]         cnt;
  logic [31:0]        wdata;
  logic               is_wr;
  logic [15:0]        lo_buf;
  logic               req;
  logic               last;
  logic               drive;
  logic               bad;
  logic [31:0]        off;
  logic [SRAM_AW-2:0] w;
  logic               unused_bits;

  assign req  = rd_en | wr_en;
  assign off  = address - 32'(BASE_ADDR);
  assign w    = off[SRAM_AW:2];
  assign last = (cnt == 3'(WAIT_CYCLES));
  assign unused_bits = ^{off[31:SRAM_AW+1], off[1:0]};

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  logic err_q;

  assign bad = (address < 32'(BASE_ADDR))
            || (off[31:SRAM_AW+1] != '0)
            || (address[1:0] != 2'b00);
  assign err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (state == IDLE && req && bad) err_q <= 1'b1;
  end
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    drive     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = !req;
        if (req) state_nx = bad ? DONE : LO;
      end
      LO: begin
        // we_n rises on the last phase cycle while data is still driven
        sram_we_n = !(is_wr && !last);
        sram_oe_n = is_wr;
        drive     = is_wr;
        if (last) state_nx = HI;
      end
      HI: begin
        sram_we_n = !(is_wr && !last);
        sram_oe_n = is_wr;
        drive     = is_wr;
        if (last) state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sram_dq = drive ? ((state == HI) ? wdata[31:16] : wdata[15:0])
                         : 16'hzzzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 3'd0;
      wdata     <= '0;
      is_wr     <= 1'b0;
      lo_buf    <= '0;
      read_data <= '0;
      sram_addr <= '0;
    end else begin
      if (state_nx == state && (state == LO || state == HI))
        cnt <= cnt + 3'd1;
      else
        cnt <= 3'd0;
      if (state == IDLE && req) begin
        wdata <= write_data;
        is_wr <= wr_en;
        if (!bad) sram_addr <= {w, 1'b0};
        if (bad && !wr_en) read_data <= '0;
      end
      if (state == LO && last) begin
        sram_addr[0] <= 1'b1;
        if (!is_wr) lo_buf <= sram_dq;
      end
      if (state == HI && last && !is_wr)
        read_data <= {sram_dq, lo_buf};
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: randomized load/store traffic against a word-level model
// and a cycle-schedule model of the SRAM strobes, plus directed literal checks.
`timescale 1ns/1ps
module tb_sram_mem_ctrl;
  localparam int BASE = 1024;
  localparam int AW   = 18;
  localparam int W    = 1;
  localparam int NW   = 1 << (AW - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   write_data = '0;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic          err;
  wire  [15:0]   sram_dq;

  logic [15:0]   mem [0:(1<<AW)-1];
  logic [31:0]   ref_mem [int];

  int            checks = 0;
  int            errors = 0;
  int            cur_op = 0;
  int            t = 0;
  int            done_t = 0;
  bit            cur_bad = 1'b0;
  bit            chk_en = 1'b0;
  bit            sticky = 1'b0;
  logic [31:0]   cur_w = '0;
  logic [31:0]   cur_data = '0;
  logic [31:0]   exp_rd = '0;
  logic [31:0]   last_rd = '0;
  logic [AW-1:0] last_addr = '0;
  int            n_nr = 0;
  int            n_we = 0;
  int            n_oe = 0;
  bit            in_lo;
  bit            in_hi;
  bit            ph_last;
  logic [AW-1:0] ea;

  sram_mem_ctrl #(
    .BASE_ADDR  (BASE),
    .SRAM_AW    (AW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

  always @(negedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d op=%0d)",
               name, act, exp, t, cur_op);
    end
  endtask

  // Expected outputs follow from the cycle schedule of the current request.
  always @(negedge clk) if (chk_en && !rst) begin
    in_lo   = cur_op != 0 && !cur_bad && t >= 1 && t <= W + 1;
    in_hi   = cur_op != 0 && !cur_bad && t >= W + 2 && t <= 2 * W + 2;
    ph_last = (t == W + 1) || (t == 2 * W + 2);
    chk("ready", ready, (cur_op == 0) || (t == done_t));
    if (in_lo || in_hi) begin
      ea = {cur_w[AW-2:0], in_hi};
      chk("addr", sram_addr, ea);
      last_addr = ea;
      if (cur_op == 2) begin
        chk("we_n", sram_we_n, ph_last);
        chk("oe_n", sram_oe_n, 1);
        chk("dq", sram_dq, in_hi ? cur_data[31:16] : cur_data[15:0]);
      end else begin
        chk("we_n", sram_we_n, 1);
        chk("oe_n", sram_oe_n, 0);
      end
    end else begin
      chk("we_n_idle", sram_we_n, 1);
      chk("oe_n_idle", sram_oe_n, 1);
      chk("addr_hold", sram_addr, last_addr);
    end
    if (cur_op == 1 && t == done_t) last_rd = exp_rd;
    chk("read_data", read_data, last_rd);
    if (cur_op != 0 && cur_bad && t >= 1) sticky = 1'b1;
    chk("err", err, sticky);
    if (!ready) n_nr++;
    if (!sram_we_n) n_we++;
    if (!sram_oe_n) n_oe++;
  end

  // op: 1 load, 2 store, 3 both enables. Called just after a rising edge.
  task automatic do_op(int op, logic [31:0] a, logic [31:0] d);
    int idx;
    rd_en      = (op == 1 || op == 3);
    wr_en      = (op >= 2);
    address    = a;
    write_data = d;
    cur_w      = (a - BASE) >> 2;
    cur_bad    = 1'b0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    cur_bad    = (a < BASE) || (cur_w >= NW) || (a[1:0] != 2'b00);
`endif
    idx      = int'(cur_w % NW);
    cur_op   = wr_en ? 2 : 1;
    cur_data = d;
    done_t   = cur_bad ? 1 : 2 * W + 3;
    if (cur_op == 1)
      exp_rd = cur_bad ? 32'h0 : (ref_mem.exists(idx) ? ref_mem[idx] : 32'h0);
    else if (!cur_bad)
      ref_mem[idx] = d;
    t = 0;
    for (int k = 1; k <= done_t; k++) begin
      @(posedge clk); #1;
      t = k;
    end
    @(posedge clk); #1;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    cur_op = 0;
    t      = 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_cnt();
    n_nr = 0; n_we = 0; n_oe = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_data", read_data, 0);
    chk("rst_ready", ready, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // abort a store mid-LO
    @(posedge clk); #1;
    wr_en = 1'b1; address = BASE; write_data = 32'h1111_2222;
    @(posedge clk); #1;
    chk("lo_we_n", sram_we_n, 0);
    #2 rst = 1'b1; wr_en = 1'b0;
    #1;
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_oe_n", sram_oe_n, 1);
    chk("abort_addr", sram_addr, 0);
    chk("abort_ready", ready, 1);
    chk("abort_read_data", read_data, 0);
    @(posedge clk); #1;
    rst = 1'b0; cur_op = 0; t = 0; last_addr = '0; last_rd = '0; sticky = 1'b0;
    chk_en = 1'b1;
    clr_cnt();
    idle(3);
    chk("abort_no_we", n_we, 0);
    do_op(2, BASE, 32'hCAFE_F00D);

    clr_cnt();
    do_op(2, 1028, 32'hDEAD_BEEF);
    chk("st_busy_cycles", n_nr, 5);
    chk("st_we_cycles", n_we, 2);
    chk("mem_w2", mem[2], 32'h0000_BEEF);
    chk("mem_w3", mem[3], 32'h0000_DEAD);

    clr_cnt();
    do_op(1, 1028, 32'h0);
    chk("ld_1028", read_data, 32'hDEAD_BEEF);
    chk("ld_oe_cycles", n_oe, 4);
    chk("ld_we_cycles", n_we, 0);

    clr_cnt();
    do_op(2, 1032, 32'h1234_5678);
    do_op(1, 1032, 32'h0);
    chk("b2b_ld", read_data, 32'h1234_5678);
    chk("b2b_we", n_we, 2);
    chk("b2b_oe", n_oe, 4);
    chk("b2b_busy", n_nr, 10);

    do_op(3, 1036, 32'hA5A5_5A5A);
    do_op(1, 1036, 32'h0);
    chk("both_en_ld", read_data, 32'hA5A5_5A5A);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    clr_cnt();
    do_op(1, 1000, 32'h0);
    chk("bad_read_data", read_data, 0);
    chk("bad_err", err, 1);
    chk("bad_no_strobe", n_we + n_oe, 0);
    chk("bad_busy", n_nr, 1);
    do_op(1, 1036, 32'h0);
    chk("err_sticky", err, 1);
`endif

    for (int i = 0; i < 200; i++) begin
      int op;
      int k;
      logic [31:0] a;
      op = int'($urandom_range(1, 3));
      k  = int'($urandom_range(0, 15));
      a  = BASE + 4 * k;
      if ($urandom_range(0, 7) == 0) a = BASE + 4 * (k + NW);
      do_op(op, a, $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
